// File: rtl/sensor_autos_emulador.sv
// rtl/sensor_autos_emulador.sv - a/b two-beam car sensor emulator with occupancy tracking
// Optional macro ABORT_EN: car backs out mid-sequence, beam walk reverses to IDLE.
module sensor_autos_emulador #(
  parameter int DWELL_CYCLES = 4,
  parameter int MAX_CARS     = 15,
  parameter int OCC_W        = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_entra_req,
  input  logic             i_sale_req,
  input  logic             i_abort,
  output logic             o_ready,
  output logic             o_a,
  output logic             o_b,
  output logic             o_done,
  output logic             o_rejected,
  output logic             o_aborted,
  output logic [OCC_W-1:0] o_occ
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [OCC_W-1:0] MAX_OCC  = OCC_W'(MAX_CARS);

  typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

  state_t           r_state;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic [OCC_W-1:0] r_occ;
  logic             r_a;
  logic             r_b;
  logic             r_ready;
  logic             r_done;
  logic             r_rejected;
  logic             r_aborted;

  logic   w_can_in;
  logic   w_can_out;
  logic   w_last;
  logic   w_rev_now;
  logic   w_back;
  state_t w_tgt;

  // Beam pattern for a phase; exit mirrors entry so each step flips one beam.
  function automatic logic [1:0] beams(input state_t s, input logic dir);
    case (s)
      S1:      beams = dir ? 2'b01 : 2'b10;
      S2:      beams = 2'b11;
      S3:      beams = dir ? 2'b10 : 2'b01;
      default: beams = 2'b00;
    endcase
  endfunction

  function automatic state_t step(input state_t s, input logic back);
    case (s)
      S1:      step = back ? IDLE : S2;
      S2:      step = back ? S1 : S3;
      S3:      step = back ? S2 : IDLE;
      default: step = IDLE;
    endcase
  endfunction

  assign w_can_in  = i_entra_req && (r_occ < MAX_OCC);
  assign w_can_out = i_sale_req && (r_occ != '0);
  assign w_last    = (r_cnt == LAST_CNT);

`ifdef ABORT_EN
  logic r_rev;
  assign w_rev_now = (r_state != IDLE) && !r_rev && i_abort;
  assign w_back    = r_rev | w_rev_now;
`else
  logic w_unused_abort;
  assign w_unused_abort = i_abort;
  assign w_rev_now      = 1'b0;
  assign w_back         = 1'b0;
`endif

  assign w_tgt = step(r_state, w_back);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_dir      <= 1'b0;
      r_cnt      <= '0;
      r_occ      <= '0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_rejected <= 1'b0;
      r_aborted  <= 1'b0;
`ifdef ABORT_EN
      r_rev      <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_rejected <= 1'b0;
      r_aborted  <= 1'b0;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (w_can_in || w_can_out) begin
          r_state      <= S1;
          r_dir        <= ~w_can_in;
          {r_a, r_b}   <= beams(S1, ~w_can_in);
          r_ready      <= 1'b0;
        end else if (i_entra_req || i_sale_req) begin
          r_rejected <= 1'b1;
        end
      end else if (w_rev_now || w_last) begin
        // Phase change: dwell expired, or abort restarts the dwell on reversal.
        r_cnt      <= '0;
        r_state    <= w_tgt;
        {r_a, r_b} <= beams(w_tgt, r_dir);
        if (w_tgt == IDLE) begin
          r_ready <= 1'b1;
          if (w_back) begin
            r_aborted <= 1'b1;
          end else begin
            r_done <= 1'b1;
            r_occ  <= r_dir ? r_occ - OCC_W'(1) : r_occ + OCC_W'(1);
          end
        end
`ifdef ABORT_EN
        r_rev <= (w_tgt == IDLE) ? 1'b0 : w_back;
`endif
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_ready    = r_ready;
  assign o_a        = r_a;
  assign o_b        = r_b;
  assign o_done     = r_done;
  assign o_rejected = r_rejected;
  assign o_aborted  = r_aborted;
  assign o_occ      = r_occ;

endmodule

// File: doc/sensor_autos_emulador.md
Name: sensor_autos_emulador

Overview:
Behavioural sensor emulator for the parking counter: the transmitter side of the two-beam a/b sensor interface that the parking I/O decoder consumes.
- Converts one-cycle "car enters" / "car leaves" requests into the exact 4-phase a/b beam sequence a real car produces.
- Tracks the resulting lot occupancy.
- Used on-board (button-driven demo) and as the stimulus source in decoder/counter benches.

Parameters:
DWELL_CYCLES, 4, clock cycles each non-idle beam phase is held (>=1)
MAX_CARS, 15, occupancy ceiling; entry requests beyond it are rejected
OCC_W, 4, width of occupancy output (must hold MAX_CARS)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
entra_req  input  1  request one entry sequence (sampled when ready=1)
sale_req  input  1  request one exit sequence (sampled when ready=1)
abort  input  1  car backs out mid-sequence (only effective with ABORT_EN)
ready  output  1  emulator idle, request will be accepted this cycle
a  output  1  outer beam, 1 = blocked
b  output  1  inner beam, 1 = blocked
done  output  1  one-cycle pulse: sequence completed, occupancy updated
rejected  output  1  one-cycle pulse: request refused (full/empty)
aborted  output  1  one-cycle pulse: sequence ended by abort (0 without ABORT_EN)
occ  output  OCC_W  cars currently inside

Behaviour:
- Single clock, synchronous active-high reset. Reset values: a=0, b=0, ready=1, done=0, rejected=0, aborted=0, occ=0, state IDLE, dwell counter 0.
- Reset mid-sequence: same values on the next edge; no done pulse; sequence discarded.
- States and beam values:
  - IDLE: a,b = 00.
  - S1, S2, S3: each holds its phase for exactly DWELL_CYCLES cycles (counter 0..DWELL_CYCLES-1).
  - Direction register dir: 0 = entry, 1 = exit.
  - Entry sequence: S1=10, S2=11, S3=01.
  - Exit sequence: S1=01, S2=11, S3=10.
- Request acceptance at edge E0 (IDLE, ready=1):
  - entra_req=1 and occ<MAX_CARS: dir=0, go to S1.
  - else sale_req=1 and occ>0: dir=1, go to S1.
  - entra_req and sale_req both high: entry has priority. sale_req is dropped (not queued).
  - Refused request (entra at occ=MAX_CARS, or sale at occ=0 with no valid entra): rejected=1 for one cycle; stay IDLE; a,b unchanged.
- ready=0 in S1..S3. Requests while busy are ignored, with no rejected pulse.
- Timing:
  - After E0: S1 occupies edges E0..E0+D, S2 E0+D..E0+2D, S3 E0+2D..E0+3D, with D=DWELL_CYCLES.
  - At edge E0+3D: state IDLE, a,b=00, done=1 for one cycle, occ incremented (entry) or decremented (exit), ready=1.
  - A request sampled in the done cycle is accepted: back-to-back sequences have zero idle gap.
- Only one of a/b changes per phase transition (Gray property), including back to 00.
- occ never wraps: guarded by the full/empty rejection above.
- done, rejected and aborted are mutually exclusive.

Optional Feature:
Macro ABORT_EN.
- Defined:
  - abort=1 sampled in S2 or S3 reverses the walk. From S3 go to S2, then S1, then IDLE; from S2 go to S1, then IDLE. Each revisited phase is held DWELL_CYCLES cycles with the same beam values as forward.
  - The dwell counter restarts on reversal.
  - abort in S1 reverses directly to IDLE at the next edge.
  - Reaching IDLE after reversal: aborted=1 for one cycle, done=0, occ unchanged.
  - abort during reversal or in IDLE is ignored.
- Not defined: abort port ignored, aborted tied 0, no reversal logic synthesized.

Test Plan:
- DWELL=2, reset, entra_req pulse at E0 -> a,b = 10,10,11,11,01,01 on E0+1..E0+6; at E0+6 a,b=00, done=1, occ=1.
- occ=1, sale_req pulse -> a,b = 01,01,11,11,10,10, then 00; done=1, occ=0.
- occ=0, entra_req and sale_req both high -> entry sequence runs, occ=1, no rejected pulse. Repeat with occ=MAX_CARS=15 and sale_req=0 -> rejected=1 for 1 cycle, a,b stay 00, occ=15.
- occ=0, sale_req alone -> rejected=1, ready stays 1. Request pulsed during S2 -> ignored, single done only.
- reset asserted during S2 of an entry -> next cycle a,b=00, occ=0, ready=1, no done pulse.
- ABORT_EN, DWELL=2: entry, abort at first S3 cycle -> a,b = 01(abort cycle), then 11,11,10,10,00; aborted=1, occ unchanged. Without ABORT_EN the same stimulus completes normally with done=1.
